pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Upstream of the memory-access stage. Owns the 16-bit program counter and produces the fetch address (pc) and the select (pc_data) that the memory-access stage latches.
- Fetches the reset vector after reset. Handles increment, absolute jump and signed relative branch, including the extra page-cross cycle.
- Single clock domain on clk_1.

Parameters:
- RESET_VEC, 16'hFFFC, address of the reset vector low byte; the high byte is at RESET_VEC+1.
- NMI_VEC, 16'hFFFA, NMI vector low-byte address; used only with MOSBY_INT_VEC_EN.
- IRQ_VEC, 16'hFFFE, IRQ vector low-byte address; used only with MOSBY_INT_VEC_EN.

Ports:
- clk_1 input 1: the block's one clock; all state updates on posedge.
- rst input 1: synchronous, active-high reset.
- data_in input 8: read data from the data bus; valid in the cycle after its address is presented.
- fetch_en input 1: control requests that the PC drive the address bus.
- pc_inc input 1: increment the PC.
- jmp_load input 1: load the PC with {jmp_hi,jmp_lo}.
- jmp_lo input 8: jump target low byte.
- jmp_hi input 8: jump target high byte.
- branch_take input 1: add branch_off to the PC.
- branch_off input 8: signed two's-complement branch offset.
- pc output 16: address offered to the memory-access stage.
- pc_data output 1: the address-bus source is the PC (instruction fetch).
- ready output 1: sequencer is in RUN and accepting commands.
- page_cross output 1: pulses in the branch fix-up cycle.

Behaviour:
- Reset: rst sampled high at posedge clk_1. On the next cycle the state is VEC_LO, with pc_reg=16'h0000, lo_buf=8'h00, ready=0, page_cross=0, pc=RESET_VEC, pc_data=1. Reset mid-operation (any state) aborts immediately and restarts at VEC_LO.
- States: VEC_LO, VEC_HI, VEC_LD, RUN, BR_FIX.
- VEC_LO: pc=vector base, pc_data=1. Goes to VEC_HI.
- VEC_HI: pc=vector base+1, pc_data=1, lo_buf<=data_in. Goes to VEC_LD.
- VEC_LD: pc=vector base+1, pc_data=0, pc_reg<={data_in,lo_buf}. Goes to RUN.
- Vector fetch latency: 3 cycles from rst deassertion to ready=1.
- RUN: ready=1, pc=pc_reg, pc_data=fetch_en.
- RUN command priority: jmp_load > branch_take > pc_inc. Only the highest-priority asserted command acts in a cycle.
  - jmp_load: pc_reg<={jmp_hi,jmp_lo}; 1 cycle.
  - pc_inc: pc_reg<=pc_reg+1; wraps 16'hFFFF -> 16'h0000.
  - branch_take: sum = pc_reg + {{8{branch_off[7]}},branch_off}, modulo 2^16.
    - If sum[15:8]==pc_reg[15:8]: pc_reg<=sum; stays in RUN.
    - Else: pc_reg[7:0]<=sum[7:0], hi_buf<=sum[15:8], go to BR_FIX.
- BR_FIX: ready=0, page_cross=1, pc shows the partially updated pc_reg (old high byte), pc_reg[15:8]<=hi_buf. Returns to RUN; a page-crossing branch takes 2 cycles total.
- Commands are ignored (no queuing) in every state other than RUN.
- Branch wrap: 16'hFFF0 + 8'h20 gives 16'h0010 with a page cross; 16'h0005 + 8'hF0 gives 16'hFFF5 with a page cross.
- The vector base is RESET_VEC unless an interrupt selected it (see Optional Feature).

Optional Feature:
- Macro MOSBY_INT_VEC_EN.
- When defined, the block adds:
  - Inputs: nmi_req(1), irq_req(1), irq_mask(1), sync(1) (opcode-fetch boundary).
  - Output: ret_pc(16), holding the PC saved for stack push.
- NMI detection: nmi_req is rising-edge detected into a nmi_pend flag; the flag clears on acceptance and on rst.
- Acceptance: in RUN with sync=1, and only if no jmp_load/branch_take is asserted that cycle.
  - nmi_pend takes priority over (irq_req & ~irq_mask).
  - On acceptance: ret_pc<=pc_reg, vector base<=NMI_VEC or IRQ_VEC, go to VEC_LO. Any pc_inc in that cycle is ignored.
- ret_pc resets to 16'h0000.
- When the macro is undefined, these ports and the nmi_pend logic are absent, and only the reset vector is used.

Test Plan:
- Reset vector fetch: rst for 2 cycles, memory returns 8'h34 at 16'hFFFC and 8'h12 at 16'hFFFD. Required: pc shows FFFC then FFFD; ready=1 on the 4th cycle after rst falls, with pc=16'h1234.
- Increment wrap: pc_reg=16'hFFFF, pc_inc=1 -> pc=16'h0000 next cycle, ready stays 1.
- Branch: pc_reg=16'h1280, branch_off=8'h10 -> pc=16'h1290 in 1 cycle, page_cross=0.
- Page-cross branch: pc_reg=16'h12F0, branch_off=8'h20 -> one cycle with pc=16'h1210, ready=0, page_cross=1, then pc=16'h1310.
- Priority and reset: jmp_load ({8'hAB,8'hCD}), branch_take and pc_inc asserted together -> pc=16'hABCD. Asserting rst during BR_FIX -> next cycle in VEC_LO with pc=16'hFFFC, ready=0, page_cross=0.
- With MOSBY_INT_VEC_EN: pc_reg=16'h4000, sync=1, irq_req=1, irq_mask=0 -> ret_pc=16'h4000, pc shows FFFE/FFFF, and the PC loads from the IRQ vector. Repeating with irq_mask=1 -> no vector fetch.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the 16-bit program counter that feeds the memory-access stage.
//
// After reset it fetches the little-endian reset vector (low byte at the vector base,
// high byte at base+1), then sits in RUN. In RUN it accepts one command per cycle:
//   jmp_load > branch_take > pc_inc.
// A branch whose target lands in another 256-byte page takes one extra cycle (BR_FIX).
// In BR_FIX, pc shows the new low byte with the old high byte. The high byte is fixed
// on the way back to RUN.
//
// Optional feature (macro MOSBY_INT_VEC_EN): NMI/IRQ acceptance at the opcode-fetch
// boundary (sync). The PC is saved in ret_pc and the vector is taken from NMI_VEC or
// IRQ_VEC. With the macro undefined, only the reset vector exists.
//
// Ports:
//   clk_1       : clock, all state changes on the rising edge
//   rst         : synchronous active-high reset
//   data_in     : read data, valid one cycle after its address was presented
//   fetch_en    : in RUN, requests the PC as the address-bus source
//   pc_inc      : increment the PC
//   jmp_load    : load the PC with {jmp_hi, jmp_lo}
//   jmp_lo/hi   : jump target bytes
//   branch_take : add the sign-extended branch_off to the PC
//   branch_off  : signed branch offset
//   pc          : address offered to the memory-access stage
//   pc_data     : address-bus source is the PC
//   ready       : in RUN and accepting commands
//   page_cross  : high during the branch fix-up cycle
//   state_dbg   : current FSM state encoding (VEC_LO=0 .. BR_FIX=4)
//   nmi_req, irq_req, irq_mask, sync, ret_pc : MOSBY_INT_VEC_EN only
//
// Handshake: there is no valid/ready pairing on commands. A command acts only in a
// cycle where ready=1; commands presented while ready=0 are dropped, not queued.

module pc_sequencer #(
  parameter logic [15:0] RESET_VEC = 16'hFFFC,
  parameter logic [15:0] NMI_VEC   = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC   = 16'hFFFE
) (
  input  logic        clk_1,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        fetch_en,
  input  logic        pc_inc,
  input  logic        jmp_load,
  input  logic [7:0]  jmp_lo,
  input  logic [7:0]  jmp_hi,
  input  logic        branch_take,
  input  logic [7:0]  branch_off,
`ifdef MOSBY_INT_VEC_EN
  input  logic        nmi_req,
  input  logic        irq_req,
  input  logic        irq_mask,
  input  logic        sync,
  output logic [15:0] ret_pc,
`endif
  output logic [15:0] pc,
  output logic        pc_data,
  output logic        ready,
  output logic        page_cross,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    VEC_LO = 3'd0,
    VEC_HI = 3'd1,
    VEC_LD = 3'd2,
    RUN    = 3'd3,
    BR_FIX = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] pc_reg;
  logic [7:0]  lo_buf;
  logic [7:0]  hi_buf;
  logic [15:0] vec_base;
  logic [15:0] br_sum;

  // Sign-extended add, modulo 2^16.
  assign br_sum = pc_reg + {{8{branch_off[7]}}, branch_off};

`ifdef MOSBY_INT_VEC_EN
  logic nmi_q;
  logic nmi_pend;
  logic int_take;

  // A jump or branch in the same cycle wins. The interrupt is then taken at a later sync.
  assign int_take = (state == RUN) && sync && !jmp_load && !branch_take &&
                    (nmi_pend || (irq_req && !irq_mask));

  // nmi_q follows the pin even during reset. A level already high when reset ends
  // therefore does not count as an edge.
  always_ff @(posedge clk_1) begin
    nmi_q <= nmi_req;
  end
`else
  assign vec_base = RESET_VEC;
`endif

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state  <= VEC_LO;
      pc_reg <= 16'h0000;
      lo_buf <= 8'h00;
      hi_buf <= 8'h00;
`ifdef MOSBY_INT_VEC_EN
      vec_base <= RESET_VEC;
      ret_pc   <= 16'h0000;
      nmi_pend <= 1'b0;
`endif
    end else begin
`ifdef MOSBY_INT_VEC_EN
      if (nmi_req && !nmi_q) nmi_pend <= 1'b1;
`endif
      case (state)
        VEC_LO: state <= VEC_HI;
        VEC_HI: begin
          lo_buf <= data_in;
          state  <= VEC_LD;
        end
        VEC_LD: begin
          pc_reg <= {data_in, lo_buf};
          state  <= RUN;
        end
        RUN: begin
          if (jmp_load) begin
            pc_reg <= {jmp_hi, jmp_lo};
          end else if (branch_take) begin
            if (br_sum[15:8] == pc_reg[15:8]) begin
              pc_reg <= br_sum;
            end else begin
              pc_reg[7:0] <= br_sum[7:0];
              hi_buf      <= br_sum[15:8];
              state       <= BR_FIX;
            end
`ifdef MOSBY_INT_VEC_EN
          end else if (int_take) begin
            ret_pc <= pc_reg;
            if (nmi_pend) begin
              vec_base <= NMI_VEC;
              nmi_pend <= 1'b0;
            end else begin
              vec_base <= IRQ_VEC;
            end
            state <= VEC_LO;
`endif
          end else if (pc_inc) begin
            pc_reg <= pc_reg + 16'h0001;
          end
        end
        BR_FIX: begin
          pc_reg[15:8] <= hi_buf;
          state        <= RUN;
        end
        default: state <= VEC_LO;
      endcase
    end
  end

  // Outputs decode directly from registered state. pc_data in RUN follows fetch_en.
  always_comb begin
    pc         = pc_reg;
    pc_data    = 1'b0;
    ready      = 1'b0;
    page_cross = 1'b0;
    case (state)
      VEC_LO: begin
        pc      = vec_base;
        pc_data = 1'b1;
      end
      VEC_HI: begin
        pc      = vec_base + 16'h0001;
        pc_data = 1'b1;
      end
      VEC_LD: begin
        pc      = vec_base + 16'h0001;
        pc_data = 1'b0;
      end
      RUN: begin
        pc      = pc_reg;
        pc_data = fetch_en;
        ready   = 1'b1;
      end
      BR_FIX: begin
        // Dummy read at the partially updated address, as the original core does.
        pc         = pc_reg;
        pc_data    = 1'b1;
        page_cross = 1'b1;
      end
      default: begin
        pc = pc_reg;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  // ---------------- clock / reset / signals ----------------
  logic clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  logic        rst, fetch_en, pc_inc, jmp_load, branch_take;
  logic [7:0]  data_in, jmp_lo, jmp_hi, branch_off;
  logic [15:0] pc;
  logic        pc_data, ready, page_cross;
  logic [2:0]  state_dbg;
`ifdef MOSBY_INT_VEC_EN
  logic        nmi_req, irq_req, irq_mask, sync;
  logic [15:0] ret_pc;
`endif

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected pc and {ready, page_cross} after each clock.
  logic [15:0] exp_q[$];
  logic [1:0]  exp_f_q[$];

  // Memory model: vector area FFF8..FFFF, everything else reads EA.
  // Data appears one cycle after the address.
  logic [7:0]  vec_mem[8];
  logic [15:0] addr_q;
  always @(posedge clk_1) addr_q <= pc;
  assign data_in = (addr_q >= 16'hFFF8) ? vec_mem[addr_q[2:0]] : 8'hEA;

  pc_sequencer dut (
    .clk_1(clk_1), .rst(rst), .data_in(data_in), .fetch_en(fetch_en),
    .pc_inc(pc_inc), .jmp_load(jmp_load), .jmp_lo(jmp_lo), .jmp_hi(jmp_hi),
    .branch_take(branch_take), .branch_off(branch_off),
`ifdef MOSBY_INT_VEC_EN
    .nmi_req(nmi_req), .irq_req(irq_req), .irq_mask(irq_mask), .sync(sync),
    .ret_pc(ret_pc),
`endif
    .pc(pc), .pc_data(pc_data), .ready(ready), .page_cross(page_cross),
    .state_dbg(state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge clk_1);
    #1;
  endtask

  task automatic clear_cmds;
    pc_inc = 1'b0; jmp_load = 1'b0; branch_take = 1'b0;
    jmp_lo = 8'h00; jmp_hi = 8'h00; branch_off = 8'h00;
`ifdef MOSBY_INT_VEC_EN
    sync = 1'b0; irq_req = 1'b0; irq_mask = 1'b0; nmi_req = 1'b0;
`endif
  endtask

  task automatic do_jmp(input logic [15:0] t);
    jmp_load = 1'b1; {jmp_hi, jmp_lo} = t;
  endtask

  task automatic push(input logic [15:0] p, input logic [1:0] f);
    exp_q.push_back(p);
    exp_f_q.push_back(f);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [15:0] e;
    logic [1:0]  f;
    logic        pd_exp;
    for (int i = 0; i < 5; i++) begin
      clear_cmds();
      fetch_en = 1'b1;
      rst = (i < 2);
      case (i)
        0, 1: begin push(16'hFFFC, 2'b00); pd_exp = 1'b1; end
        2:    begin push(16'hFFFD, 2'b00); pd_exp = 1'b1; end
        3:    begin push(16'hFFFD, 2'b00); pd_exp = 1'b0; end
        default: begin push(16'h1234, 2'b10); pd_exp = 1'b1; end
      endcase
      step();
      e = exp_q.pop_front();
      f = exp_f_q.pop_front();
      total++;
      if ({pc, ready, page_cross, pc_data} !== {e, f, pd_exp}) begin
        bad++;
        $display("FAIL reset[%0d] pc=%h rdy=%b pcx=%b pd=%b expected pc=%h rdy=%b pcx=%b pd=%b",
                 i, pc, ready, page_cross, pc_data, e, f[1], f[0], pd_exp);
      end
    end
  endtask

  task automatic test_inc_wrap;
    logic [15:0] e;
    logic [1:0]  f;
    for (int i = 0; i < 4; i++) begin
      clear_cmds();
      fetch_en = (i != 3);
      case (i)
        0: begin do_jmp(16'hFFFF); push(16'hFFFF, 2'b10); end
        1: begin pc_inc = 1'b1;    push(16'h0000, 2'b10); end
        2: begin pc_inc = 1'b1;    push(16'h0001, 2'b10); end
        default:                   push(16'h0001, 2'b10);
      endcase
      step();
      e = exp_q.pop_front();
      f = exp_f_q.pop_front();
      total++;
      if ({pc, ready, page_cross, pc_data} !== {e, f, (i != 3)}) begin
        bad++;
        $display("FAIL inc_wrap[%0d] pc=%h rdy=%b pcx=%b pd=%b expected pc=%h rdy=%b pcx=%b pd=%b",
                 i, pc, ready, page_cross, pc_data, e, f[1], f[0], (i != 3));
      end
    end
  endtask

  task automatic test_branch;
    logic [15:0] e;
    logic [1:0]  f;
    for (int i = 0; i < 3; i++) begin
      clear_cmds();
      case (i)
        0: begin do_jmp(16'h1280); push(16'h1280, 2'b10); end
        1: begin branch_take = 1'b1; branch_off = 8'h10; push(16'h1290, 2'b10); end
        default: begin branch_take = 1'b1; branch_off = 8'hE0; push(16'h1270, 2'b10); end
      endcase
      step();
      e = exp_q.pop_front();
      f = exp_f_q.pop_front();
      total++;
      if ({pc, ready, page_cross} !== {e, f}) begin
        bad++;
        $display("FAIL branch[%0d] pc=%h rdy=%b pcx=%b expected pc=%h rdy=%b pcx=%b",
                 i, pc, ready, page_cross, e, f[1], f[0]);
      end
    end
  endtask

  task automatic test_page_cross;
    logic [15:0] e;
    logic [1:0]  f;
    for (int i = 0; i < 10; i++) begin
      clear_cmds();
      case (i)
        0: begin do_jmp(16'h12F0); push(16'h12F0, 2'b10); end
        1: begin branch_take = 1'b1; branch_off = 8'h20; push(16'h1210, 2'b01); end
        2: begin pc_inc = 1'b1; push(16'h1310, 2'b10); end  // dropped in BR_FIX
        3: begin do_jmp(16'hFFF0); push(16'hFFF0, 2'b10); end
        4: begin branch_take = 1'b1; branch_off = 8'h20; push(16'hFF10, 2'b01); end
        5: push(16'h0010, 2'b10);
        6: begin do_jmp(16'h0005); push(16'h0005, 2'b10); end
        7: begin branch_take = 1'b1; branch_off = 8'hF0; push(16'h00F5, 2'b01); end
        8: push(16'hFFF5, 2'b10);
        default: begin branch_take = 1'b1; branch_off = 8'hF0; push(16'hFFE5, 2'b10); end
      endcase
      step();
      e = exp_q.pop_front();
      f = exp_f_q.pop_front();
      total++;
      if ({pc, ready, page_cross} !== {e, f}) begin
        bad++;
        $display("FAIL page_cross[%0d] pc=%h rdy=%b pcx=%b expected pc=%h rdy=%b pcx=%b",
                 i, pc, ready, page_cross, e, f[1], f[0]);
      end
    end
  endtask

  task automatic test_priority;
    logic [15:0] e;
    logic [1:0]  f;
    for (int i = 0; i < 3; i++) begin
      clear_cmds();
      case (i)
        0: begin do_jmp(16'hABCD); branch_take = 1'b1; branch_off = 8'h10; pc_inc = 1'b1;
                 push(16'hABCD, 2'b10); end
        1: begin branch_take = 1'b1; branch_off = 8'h10; pc_inc = 1'b1;
                 push(16'hABDD, 2'b10); end
        default: begin pc_inc = 1'b1; push(16'hABDE, 2'b10); end
      endcase
      step();
      e = exp_q.pop_front();
      f = exp_f_q.pop_front();
      total++;
      if ({pc, ready, page_cross} !== {e, f}) begin
        bad++;
        $display("FAIL priority[%0d] pc=%h rdy=%b pcx=%b expected pc=%h rdy=%b pcx=%b",
                 i, pc, ready, page_cross, e, f[1], f[0]);
      end
    end
  endtask

  task automatic test_reset_in_fix;
    logic [15:0] e;
    logic [1:0]  f;
    for (int i = 0; i < 6; i++) begin
      clear_cmds();
      rst = (i == 2);
      case (i)
        0: begin do_jmp(16'h12F0); push(16'h12F0, 2'b10); end
        1: begin branch_take = 1'b1; branch_off = 8'h20; push(16'h1210, 2'b01); end
        2: push(16'hFFFC, 2'b00);
        3: begin do_jmp(16'h0000); push(16'hFFFD, 2'b00); end  // dropped outside RUN
        4: begin pc_inc = 1'b1; push(16'hFFFD, 2'b00); end      // dropped outside RUN
        default: push(16'h1234, 2'b10);
      endcase
      step();
      e = exp_q.pop_front();
      f = exp_f_q.pop_front();
      total++;
      if ({pc, ready, page_cross} !== {e, f}) begin
        bad++;
        $display("FAIL reset_in_fix[%0d] pc=%h rdy=%b pcx=%b expected pc=%h rdy=%b pcx=%b",
                 i, pc, ready, page_cross, e, f[1], f[0]);
      end
    end
  endtask

  // Random command mix against a reference PC model.
  task automatic test_random;
    logic [15:0] m_pc, sum, e;
    logic [7:0]  fix_hi;
    logic        in_fix;
    logic [1:0]  f;
    clear_cmds();
    do_jmp(16'h8000);
    step();
    m_pc = 16'h8000; in_fix = 1'b0; fix_hi = 8'h00;
    for (int i = 0; i < 60; i++) begin
      clear_cmds();
      jmp_load    = ($urandom_range(0, 7) == 0);
      branch_take = ($urandom_range(0, 2) == 0);
      pc_inc      = ($urandom_range(0, 1) == 1);
      {jmp_hi, jmp_lo} = 16'($urandom_range(0, 16'hFFFF));
      branch_off  = 8'($urandom_range(0, 255));
      if (in_fix) begin
        m_pc = {fix_hi, m_pc[7:0]};
        in_fix = 1'b0;
      end else if (jmp_load) begin
        m_pc = {jmp_hi, jmp_lo};
      end else if (branch_take) begin
        sum = m_pc + {{8{branch_off[7]}}, branch_off};
        if (sum[15:8] == m_pc[15:8]) m_pc = sum;
        else begin
          m_pc[7:0] = sum[7:0];
          fix_hi = sum[15:8];
          in_fix = 1'b1;
        end
      end else if (pc_inc) begin
        m_pc = m_pc + 16'h0001;
      end
      push(m_pc, in_fix ? 2'b01 : 2'b10);
      step();
      e = exp_q.pop_front();
      f = exp_f_q.pop_front();
      total++;
      if ({pc, ready, page_cross} !== {e, f}) begin
        bad++;
        $display("FAIL random[%0d] pc=%h rdy=%b pcx=%b expected pc=%h rdy=%b pcx=%b",
                 i, pc, ready, page_cross, e, f[1], f[0]);
      end
    end
    clear_cmds();
    step();
  endtask

`ifdef MOSBY_INT_VEC_EN
  task automatic test_interrupts;
    logic [15:0] e;
    logic [1:0]  f;
    for (int i = 0; i < 12; i++) begin
      clear_cmds();
      case (i)
        0: begin do_jmp(16'h4000); push(16'h4000, 2'b10); end
        1: begin sync = 1'b1; irq_req = 1'b1; pc_inc = 1'b1; push(16'hFFFE, 2'b00); end
        2, 3: push(16'hFFFF, 2'b00);
        4: push(16'h5678, 2'b10);
        5: begin do_jmp(16'h4000); push(16'h4000, 2'b10); end
        6: begin sync = 1'b1; irq_req = 1'b1; irq_mask = 1'b1; push(16'h4000, 2'b10); end
        7: begin nmi_req = 1'b1; irq_req = 1'b1; irq_mask = 1'b1; push(16'h4000, 2'b10); end
        8: begin sync = 1'b1; push(16'hFFFA, 2'b00); end
        9, 10: push(16'hFFFB, 2'b00);
        default: push(16'h9ABC, 2'b10);
      endcase
      step();
      e = exp_q.pop_front();
      f = exp_f_q.pop_front();
      total++;
      if ({pc, ready, page_cross} !== {e, f}) begin
        bad++;
        $display("FAIL interrupts[%0d] pc=%h rdy=%b pcx=%b expected pc=%h rdy=%b pcx=%b",
                 i, pc, ready, page_cross, e, f[1], f[0]);
      end
      if (i == 1 || i == 8) begin
        total++;
        if (ret_pc !== 16'h4000) begin
          bad++;
          $display("FAIL ret_pc[%0d] got=%h expected=4000", i, ret_pc);
        end
      end
    end
  endtask
`endif

  // ---------------- main sequence and report ----------------
  initial begin
    rst = 1'b1; fetch_en = 1'b1;
    clear_cmds();
    for (int k = 0; k < 8; k++) vec_mem[k] = 8'h00;
    vec_mem[2] = 8'hBC; vec_mem[3] = 8'h9A;  // FFFA/FFFB: NMI vector
    vec_mem[4] = 8'h34; vec_mem[5] = 8'h12;  // FFFC/FFFD: reset vector
    vec_mem[6] = 8'h78; vec_mem[7] = 8'h56;  // FFFE/FFFF: IRQ vector
    test_reset();
    test_inc_wrap();
    test_branch();
    test_page_cross();
    test_priority();
    test_reset_in_fix();
    test_random();
`ifdef MOSBY_INT_VEC_EN
    test_interrupts();
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
